// File: rtl/xsm_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// xsm_fifo_wr_arbiter
//
// Round-robin write arbiter that shares the single write port of an xsm_fifo
// among NUM_REQ producer engines.
//
// A requester is granted for one burst. The burst ends on a beat carrying
// req_last, or is cut after MAX_BURST beats so that one long producer cannot
// starve the others. A cut burst simply re-arbitrates for its remaining beats.
// A new grant is only issued when the FIFO has room for a full MAX_BURST
// burst. Once granted, the burst can therefore stream without checking the
// fill level again. fifo_full still stalls individual beats.
//
// Ports
//   clk              clock
//   rst_n            asynchronous active-low reset
//   req_valid        per-requester beat valid
//   req_data         requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last         per-requester last-beat-of-burst flag
//   req_ready        per-requester accept; a beat moves when valid & ready
//   fifo_wr_en       FIFO write strobe
//   fifo_wr_data     FIFO write data (data of the granted requester)
//   fifo_full        FIFO full flag
//   fifo_fill_level  FIFO occupancy, 0 .. FIFO_DEPTH
//   grant_id         current grant, or the last one while idle
//   busy             high while a burst is in progress
//   trunc_cnt        saturating count of bursts cut at MAX_BURST beats
// -----------------------------------------------------------------------------
module xsm_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 1024,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    input  logic                            fifo_full,
    input  logic [$clog2(FIFO_DEPTH):0]     fifo_fill_level,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [15:0]                     trunc_cnt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;   // fill level width
    localparam int GW = $clog2(NUM_REQ);          // requester index width
    localparam int BW = $clog2(MAX_BURST + 1);    // beat counter width

    // One extra bit over the fill level so level + MAX_BURST cannot wrap.
    typedef logic [LW:0] lvl_ext_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_last;      // requester that finished the previous burst
    logic [BW-1:0]   beat_cnt;     // beats accepted in the current grant

    logic            room_ok;
    logic            win_found;
    logic [GW-1:0]   win_id;
    logic            in_xfer;
    logic            g_valid;
    logic            g_last;
    logic            beat_ok;
    logic            burst_cap;

    // -------------------------------------------------------------------------
    // Admission: the whole worst-case burst must fit in the FIFO.
    // -------------------------------------------------------------------------
    assign room_ok = (lvl_ext_t'(fifo_fill_level) + lvl_ext_t'(MAX_BURST))
                     <= lvl_ext_t'(FIFO_DEPTH);

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester after rr_last, wrapping around.
    // rr_last itself is scanned last, so it only wins when nobody else is valid.
    // -------------------------------------------------------------------------
    always_comb begin
        int            idx_int;
        logic [GW-1:0] idx;
        // NOTE: every variable gets a default before any conditional write;
        // a path that leaves one unassigned would infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        idx_int   = 0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_int = (int'(rr_last) + k) % NUM_REQ;
            idx     = GW'(idx_int);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath of the granted requester. Ready follows fifo_full directly so
    // a full FIFO stalls the beat in the same cycle.
    // -------------------------------------------------------------------------
    assign in_xfer   = (state == XFER);
    assign g_valid   = req_valid[grant_id];
    assign g_last    = req_last[grant_id];
    assign beat_ok   = in_xfer && g_valid && !fifo_full;
    assign burst_cap = (beat_cnt == BW'(MAX_BURST - 1));

    always_comb begin
        req_ready = '0;
        if (in_xfer && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign fifo_wr_en   = beat_ok;
    assign fifo_wr_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    // -------------------------------------------------------------------------
    // Control FSM. grant_id deliberately holds its value in IDLE. A requester
    // that drops valid mid-burst keeps the grant; there is no timeout.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_last   <= GW'(NUM_REQ - 1);   // requester 0 gets first priority
            beat_cnt  <= '0;
            busy      <= 1'b0;
            trunc_cnt <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values; blocking writes here would
            // make later statements see already-updated state.
            case (state)
                IDLE: begin
                    if (win_found && room_ok) begin
                        grant_id <= win_id;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end

                XFER: begin
                    if (beat_ok) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (g_last) begin
                            // A last beat that also hits the cap is a normal end.
                            rr_last <= grant_id;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (burst_cap) begin
                            // Forced release; the remaining beats re-arbitrate.
                            rr_last <= grant_id;
                            busy    <= 1'b0;
                            state   <= IDLE;
                            if (trunc_cnt != 16'hFFFF) begin
                                trunc_cnt <= trunc_cnt + 16'd1;
                            end
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xsm_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xsm_fifo_wr_arbiter
//
// Each requester is driven from a queue of beats and stays valid while its
// queue holds data. When a set of bursts is loaded, a transaction-level model
// works out the order of FIFO writes from the arbitration rules: round-robin
// order, end on last, cut at MAX_BURST. The model pushes the expected writes
// into a scoreboard queue. A separate monitor pops one entry per fifo_wr_en
// and compares data and grant. Directed scenarios and randomized phases
// (random fifo_full stalls and fill levels) use the same machinery.
// -----------------------------------------------------------------------------
module tb_xsm_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 128;
    localparam int DEPTH   = 1024;
    localparam int MAXB    = 16;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int GW      = $clog2(NUM_REQ);
    localparam int CW      = DW + 16;

    typedef logic [CW-1:0] cv_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [GW-1:0] id;
        logic [DW-1:0] data;
    } wr_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*DW-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]      req_last = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    fifo_wr_en;
    logic [DW-1:0]           fifo_wr_data;
    logic                    fifo_full = 1'b0;
    logic [LW-1:0]           fifo_fill_level = '0;
    logic [GW-1:0]           grant_id;
    logic                    busy;
    logic [15:0]             trunc_cnt;

    xsm_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .MAX_BURST (MAXB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_full      (fifo_full),
        .fifo_fill_level(fifo_fill_level),
        .grant_id       (grant_id),
        .busy           (busy),
        .trunc_cnt      (trunc_cnt)
    );

    always #5 clk = ~clk;

    // Driver and model state.
    beat_t              drv_q[NUM_REQ][$];
    beat_t              mdl_q[NUM_REQ][$];
    wr_t                exp_q[$];
    int                 m_rr_last = NUM_REQ - 1;
    int                 m_trunc   = 0;
    int                 written   = 0;
    int                 tests     = 0;
    int                 fails     = 0;
    logic [NUM_REQ-1:0] fire      = '0;
    bit                 rand_full  = 1'b0;
    bit                 rand_level = 1'b0;
    bit                 force_full = 1'b0;
    logic [LW-1:0]      fixed_level = '0;

    task automatic check(input string name, input cv_t got, input cv_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_q[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: retire beats accepted at the previous edge, then drive new
    // inputs on the falling edge and note which beats the next edge takes.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        end
        fifo_full = force_full || (rand_full && ($urandom_range(0, 4) == 0));
        if (rand_level) begin
            if ($urandom_range(0, 2) == 0)
                fifo_fill_level = LW'($urandom_range(990, DEPTH - 1));
            else
                fifo_fill_level = LW'($urandom_range(0, DEPTH - MAXB));
        end else begin
            fifo_fill_level = fixed_level;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drv_q[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = drv_q[i][0].data;
                req_last[i]           = drv_q[i][0].last;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = rand_word();
                req_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        #1;
        fire = req_valid & req_ready;
    endtask

    task automatic add_burst(input int r, input int len);
        beat_t b;
        for (int n = 1; n <= len; n++) begin
            b.data = rand_word();
            b.data[DW-1 -: 8] = 8'(r);
            b.last = (n == len);
            drv_q[r].push_back(b);
            mdl_q[r].push_back(b);
        end
    endtask

    // Transaction-level arbitration: choose the next requester with pending
    // beats after the previous winner, take beats up to last or MAXB.
    task automatic run_model();
        bit    more;
        bit    done;
        int    g;
        int    n;
        beat_t b;
        wr_t   e;
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (g < 0 && mdl_q[(m_rr_last + k) % NUM_REQ].size() > 0)
                    g = (m_rr_last + k) % NUM_REQ;
            end
            if (g < 0) begin
                more = 1'b0;
            end else begin
                n    = 0;
                done = 1'b0;
                while (!done) begin
                    b      = mdl_q[g].pop_front();
                    e.id   = GW'(g);
                    e.data = b.data;
                    exp_q.push_back(e);
                    n++;
                    if (b.last) begin
                        done = 1'b1;
                    end else if (n == MAXB) begin
                        done = 1'b1;
                        if (m_trunc < 65535) m_trunc++;
                    end
                end
                m_rr_last = g;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy || pending()) && n < 6000) begin
            step();
            n++;
        end
        tests++;
        if (n >= 6000) begin
            fails++;
            $display("FAIL %s: drain timeout, %0d writes still expected", name, exp_q.size());
            exp_q.delete();
            for (int i = 0; i < NUM_REQ; i++) drv_q[i].delete();
        end
    endtask

    // Scoreboard monitor.
    initial begin
        wr_t                e;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (!busy) check("idle_ready_low", cv_t'(req_ready), cv_t'(0));
                if (busy && fifo_full) begin
                    check("full_no_write", cv_t'(fifo_wr_en), cv_t'(0));
                    check("full_ready_low", cv_t'(req_ready), cv_t'(0));
                end
                if (fifo_wr_en) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got data %0h from grant %0d, none expected",
                                 fifo_wr_data, grant_id);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.id] = 1'b1;
                        check("wr_data", cv_t'(fifo_wr_data), cv_t'(e.data));
                        check("wr_grant", cv_t'(grant_id), cv_t'(e.id));
                        check("wr_ready_onehot", cv_t'(req_ready), cv_t'(oh));
                    end
                    written++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        int nb;
        int len;

        // Reset values, checked while reset is held and right after release.
        step();
        check("rst_ready", cv_t'(req_ready), cv_t'(0));
        check("rst_wr_en", cv_t'(fifo_wr_en), cv_t'(0));
        check("rst_grant", cv_t'(grant_id), cv_t'(0));
        check("rst_busy", cv_t'(busy), cv_t'(0));
        check("rst_trunc", cv_t'(trunc_cnt), cv_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", cv_t'(busy), cv_t'(0));
        check("post_rst_grant", cv_t'(grant_id), cv_t'(0));

        // All four requesters with 1-beat bursts: order 0,1,2,3,0.
        add_burst(0, 1); add_burst(0, 1);
        add_burst(1, 1); add_burst(2, 1); add_burst(3, 1);
        run_model();
        wait_drain("t1_rr_order");

        // Requester 2 alone, 5-beat burst; grant_id then holds 2 while idle.
        add_burst(2, 5);
        run_model();
        wait_drain("t2_burst5");
        step();
        check("t2_busy_end", cv_t'(busy), cv_t'(0));
        check("t2_grant_hold", cv_t'(grant_id), cv_t'(2));

        // 20 beats without an early last: cut at 16, then 4 more.
        add_burst(1, 20);
        run_model();
        wait_drain("t3_trunc");
        check("t3_trunc_cnt", cv_t'(trunc_cnt), cv_t'(m_trunc));

        // Admission boundary: 1009 blocks, 1008 admits at the next edge.
        fixed_level = LW'(1009);
        add_burst(0, 3);
        run_model();
        for (int i = 0; i < 6; i++) step();
        check("t4_blocked_busy", cv_t'(busy), cv_t'(0));
        check("t4_blocked_ready", cv_t'(req_ready), cv_t'(0));
        fixed_level = LW'(1008);
        step();
        step();
        check("t4_grant_next", cv_t'(busy), cv_t'(1));
        check("t4_grant_id", cv_t'(grant_id), cv_t'(0));
        force_full = 1'b1;
        step();
        check("t4_full_ready", cv_t'(req_ready), cv_t'(0));
        check("t4_full_wr_en", cv_t'(fifo_wr_en), cv_t'(0));
        force_full  = 1'b0;
        fixed_level = '0;
        wait_drain("t4_drain");

        // Reset in the middle of a burst.
        add_burst(2, 10);
        run_model();
        w0 = written;
        n  = 0;
        while (written < w0 + 3 && n < 200) begin
            step();
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL t5_reach_beat3: got %0d writes expected 3", written - w0);
        end
        step();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        fire      = '0;
        m_rr_last = NUM_REQ - 1;
        m_trunc   = 0;
        #1;
        check("t5_ready", cv_t'(req_ready), cv_t'(0));
        check("t5_wr_en", cv_t'(fifo_wr_en), cv_t'(0));
        check("t5_busy", cv_t'(busy), cv_t'(0));
        check("t5_trunc", cv_t'(trunc_cnt), cv_t'(0));
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        add_burst(0, 1); add_burst(1, 1); add_burst(2, 1); add_burst(3, 1);
        run_model();
        wait_drain("t5_after_reset");

        // Last on beat 16 is a normal end; 17 beats is one cut.
        add_burst(3, 16);
        run_model();
        wait_drain("t6_last_at_cap");
        check("t6_trunc_same", cv_t'(trunc_cnt), cv_t'(m_trunc));
        add_burst(0, 17);
        run_model();
        wait_drain("t6_over_cap");
        check("t6_trunc_inc", cv_t'(trunc_cnt), cv_t'(m_trunc));

        // Randomized phases with stalls and fluctuating fill level.
        rand_full  = 1'b1;
        rand_level = 1'b1;
        for (int p = 0; p < 25; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(0, 3) == 0) len = $urandom_range(15, 17);
                    else                           len = $urandom_range(1, 32);
                    add_burst(r, len);
                end
            end
            run_model();
            wait_drain("rand_drain");
            check("rand_trunc", cv_t'(trunc_cnt), cv_t'(m_trunc));
        end
        rand_full  = 1'b0;
        rand_level = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
